nibble_serial_adder: RTL

//  Multi-cycle wide adder that feeds operands 4 bits per cycle through a 4-bit

---
 rtl/nibble_serial_adder_if.sv | 27 ++
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit slice, stepping one nibble per cycle with a
// registered carry. One operation in flight; results are held until taken.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   nibble_serial_adder_if.slave bus,
   output logic [1:0]           dbg_state
);
   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  work_q, work_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic [4:0]        nib_res;
   logic              in_ready_int;
   int                nib_base;

   assign in_ready_int = (state_q == S_IDLE) && !rst;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      nib_base = 4 * int'(idx_q);
      nib_res  = {1'b0, a_q[nib_base +: 4]} + {1'b0, b_q[nib_base +: 4]} + {4'b0000, carry_q};

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_int) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               carry_d = bus.in_cin;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            work_d[nib_base +: 4] = nib_res[3:0];
            carry_d               = nib_res[4];
            if (idx_q == IDXW'(NIB - 1)) begin
               // Outputs are only loaded here, so partial sums never leak out.
               sum_d   = work_d;
               cout_d  = nib_res[4];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;
   assign dbg_state     = state_q;
endmodule
